// File: rtl/dac_pkg.sv
// dac_pkg: shared encodings for the DAC waveform generator and SPI framer.
package dac_pkg;
  localparam logic [1:0] WAVE_SQUARE = 2'b00;
  localparam logic [1:0] WAVE_SAW    = 2'b01;
  localparam logic [1:0] WAVE_TRI    = 2'b10;
  localparam logic [1:0] WAVE_DC     = 2'b11;
  localparam int         FRAME_BITS  = 16;
  localparam logic [3:0] CTRL_BITS   = 4'b0000;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
endpackage

// File: rtl/dac_wave_gen.sv
// dac_wave_gen: maps an accumulator phase and shape select to one DAC sample.
module dac_wave_gen
  import dac_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 16
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         wave_sel,
  output logic [DATA_W-1:0]  sample
);
  logic [DATA_W-1:0] tri_lin;
  logic              unused_lsb;
  always_comb begin
    tri_lin    = phase[PHASE_W-2 -: DATA_W];
    unused_lsb = ^phase[PHASE_W-DATA_W-2:0];
    sample     = wave_sel == WAVE_SQUARE ? {DATA_W{phase[PHASE_W-1]}} :
                 wave_sel == WAVE_SAW    ? phase[PHASE_W-1 -: DATA_W] :
                 wave_sel == WAVE_TRI    ? (phase[PHASE_W-1] ? ~tri_lin : tri_lin) :
                                           {1'b1, {(DATA_W-1){1'b0}}};
  end
endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: turns DAC_CLOCK strobes into phase-accumulated waveform
// samples and serializes each one as a 16-bit SPI frame to the board DAC.
module dac_spi_driver
  import dac_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int PHASE_W  = 16,
  parameter int SCLK_DIV = 4,
  parameter int GAP_CYC  = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               DAC_CLOCK,
  input  logic               ENABLE,
  input  logic [1:0]         WAVE_SEL,
  input  logic [PHASE_W-1:0] FREQ_WORD,
  output logic               DAC_SCLK,
  output logic               DAC_SYNC_N,
  output logic               DAC_DIN,
  output logic [DATA_W-1:0]  SAMPLE_OUT,
  output logic               BUSY,
  output logic               OVERRUN
);
  localparam int BIT_CYC = 2 * SCLK_DIV;
  localparam int CNT_MAX = BIT_CYC > GAP_CYC ? BIT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS);

  state_t                state_q, state_d;
  logic                  s1_q, s2_q, s3_q, strobe;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [DATA_W-1:0]     sample, pend_q, pend_d, sample_q, sample_d;
  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  sclk_q, sclk_d, sync_q, sync_d, din_q, din_d, ovr_q, ovr_d;
  logic                  bit_end, last_bit, gap_end;

  // Shape is taken from the already-advanced phase so the frame reflects this strobe.
  dac_wave_gen #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) u_wave (
    .phase   (phase_d),
    .wave_sel(WAVE_SEL),
    .sample  (sample)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      phase_q  <= '0;
      pend_q   <= '0;
      sample_q <= '0;
      sreg_q   <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b1;
      sync_q   <= 1'b1;
      din_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= DAC_CLOCK;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      sample_q <= sample_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      sync_q   <= sync_d;
      din_q    <= din_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    strobe   = s2_q & ~s3_q & ENABLE;
    phase_d  = strobe ? phase_q + FREQ_WORD : phase_q;
    bit_end  = cnt_q == CNT_W'(BIT_CYC);
    last_bit = bit_q == '0;
    gap_end  = cnt_q == CNT_W'(GAP_CYC - 1);
    state_d  = state_q;
    case (state_q)
      IDLE:    state_d = strobe ? LOAD : IDLE;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = bit_end && last_bit ? GAP : SHIFT;
      GAP:     state_d = gap_end ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d   = state_q == IDLE && strobe ? sample : pend_q;
    sample_d = state_q == LOAD ? pend_q : sample_q;
    ovr_d    = strobe && state_q != IDLE;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sclk_d   = 1'b1;
    sync_d   = sync_q;
    din_d    = din_q;
    case (state_q)
      LOAD: begin
        sreg_d = {CTRL_BITS, pend_q};
        cnt_d  = '0;
        bit_d  = BIT_W'(FRAME_BITS - 1);
        sync_d = 1'b0;
        din_d  = sreg_d[FRAME_BITS-1];
      end
      SHIFT: begin
        cnt_d  = bit_end ? (last_bit ? '0 : CNT_W'(1)) : cnt_q + 1'b1;
        sclk_d = cnt_d <= CNT_W'(SCLK_DIV);
        if (bit_end) begin
          sreg_d = sreg_q << 1;
          bit_d  = bit_q - 1'b1;
          sync_d = last_bit;
          din_d  = !last_bit && sreg_d[FRAME_BITS-1];
        end
      end
      GAP:     cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    DAC_SCLK   = sclk_q;
    DAC_SYNC_N = sync_q;
    DAC_DIN    = din_q;
    SAMPLE_OUT = sample_q;
    BUSY       = state_q != IDLE;
    OVERRUN    = ovr_q;
  end
endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: directed strobes against a cycle-timing model of the
// DAC pins, plus literal frame/sample expectations for each waveform.
module tb_dac_spi_driver;
  localparam int D  = 4;
  localparam int G  = 8;
  localparam int FL = 1 + 32 * D;

  logic        CLOCK = 1'b0, RESET = 1'b1, DAC_CLOCK = 1'b0, ENABLE = 1'b0;
  logic [1:0]  WAVE_SEL = 2'b00;
  logic [15:0] FREQ_WORD = 16'h0000;
  logic        DAC_SCLK, DAC_SYNC_N, DAC_DIN, BUSY, OVERRUN;
  logic [11:0] SAMPLE_OUT;
  int          total = 0, bad = 0;

  dac_spi_driver #(.DATA_W(12), .PHASE_W(16), .SCLK_DIV(D), .GAP_CYC(G)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .DAC_CLOCK (DAC_CLOCK),
    .ENABLE    (ENABLE),
    .WAVE_SEL  (WAVE_SEL),
    .FREQ_WORD (FREQ_WORD),
    .DAC_SCLK  (DAC_SCLK),
    .DAC_SYNC_N(DAC_SYNC_N),
    .DAC_DIN   (DAC_DIN),
    .SAMPLE_OUT(SAMPLE_OUT),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] shape(input logic [15:0] p, input logic [1:0] w);
    case (w)
      2'd0:    return p >= 16'h8000 ? 12'hFFF : 12'h000;
      2'd1:    return 12'(p / 16);
      2'd2:    return p >= 16'h8000 ? 12'(4095 - (p % 32768) / 8) : 12'((p % 32768) / 8);
      default: return 12'h800;
    endcase
  endfunction

  // Model: frame timing as offsets from the edge u where the phase advanced.
  int          cyc = 0, u = -100000, ovr_at = -100000;
  logic [15:0] ph = 0;
  logic [11:0] cur = 0, prv = 0;
  logic        ha = 0, hb = 0, hc = 0;
  bit          valid = 0;

  initial forever begin
    @(posedge CLOCK);
    cyc++;
    if (RESET) begin
      u = -100000; ovr_at = -100000; ph = 0; cur = 0; prv = 0;
      ha = 0; hb = 0; hc = 0; valid = 1;
    end else begin
      if (hb && !hc && ENABLE) begin
        ph = ph + FREQ_WORD;
        if (cyc - 1 >= u && cyc - 1 <= u + FL + G) ovr_at = cyc;
        else begin
          u = cyc; prv = cur; cur = shape(ph, WAVE_SEL);
        end
      end
      hc = hb; hb = ha; ha = DAC_CLOCK;
    end
  end

  int          m, j;
  logic [15:0] mw;
  logic        e_sync, e_sclk, e_din;
  initial forever begin
    @(negedge CLOCK);
    if (valid && !RESET) begin
      m  = cyc;
      j  = m - u - 2;
      mw = {4'b0000, cur};
      e_sync = !(m >= u + 1 && m <= u + FL);
      e_sclk = (j >= 0 && j < 32 * D) ? ((j % (2 * D)) < D) : 1'b1;
      e_din  = (m == u + 1) ? mw[15] : (j >= 0 && j < 32 * D) ? mw[15 - j / (2 * D)] : 1'b0;
      chk("pin_sync", DAC_SYNC_N, e_sync);
      chk("pin_sclk", DAC_SCLK, e_sclk);
      chk("pin_din", DAC_DIN, e_din);
      chk("pin_busy", BUSY, m >= u && m <= u + FL + G);
      chk("pin_ovr", OVERRUN, m == ovr_at);
      chk("pin_sample", SAMPLE_OUT, m >= u + 1 ? cur : prv);
    end
  end

  typedef struct {logic [15:0] w; int falls; int low; int spbad;} frame_t;
  frame_t      frames_q[$];
  int          ncyc = 0, nfall = 0, lowlen = 0, spbad = 0, lastfall = 0, ovr_cnt = 0;
  logic [15:0] cap = 0;
  logic        p_sclk = 1, p_sync = 1;
  initial forever begin
    @(negedge CLOCK);
    ncyc++;
    if (RESET) begin
      nfall = 0; lowlen = 0; cap = 0; spbad = 0;
    end else begin
      if (!DAC_SYNC_N) begin
        lowlen++;
        if (p_sclk && !DAC_SCLK) begin
          cap = {cap[14:0], DAC_DIN};
          if (nfall > 0 && ncyc - lastfall != 2 * D) spbad++;
          lastfall = ncyc;
          nfall++;
        end
      end else if (!p_sync) begin
        frames_q.push_back('{cap, nfall, lowlen, spbad});
        nfall = 0; lowlen = 0; cap = 0; spbad = 0;
      end
      if (OVERRUN) ovr_cnt++;
    end
    p_sclk = DAC_SCLK;
    p_sync = DAC_SYNC_N;
  end

  function automatic frame_t fr(input int i);
    frame_t none = '{16'hDEAD, -1, -1, -1};
    return i < frames_q.size() ? frames_q[i] : none;
  endfunction

  task automatic check_frame(input string nm, input int i, input logic [15:0] w);
    frame_t f = fr(i);
    chk({nm, "_word"}, f.w, w);
    chk({nm, "_falls"}, f.falls, 16);
    chk({nm, "_low"}, f.low, FL);
    chk({nm, "_spacing"}, f.spbad, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!BUSY) return;
      @(negedge CLOCK);
    end
    total++; bad++;
    $display("FAIL idle_timeout: BUSY still high at %0t", $time);
  endtask

  task automatic strobe();
    @(negedge CLOCK); DAC_CLOCK = 1'b1;
    repeat (10) @(negedge CLOCK); DAC_CLOCK = 1'b0;
    repeat (10) @(negedge CLOCK);
    wait_idle();
  endtask

  task automatic reset_pulse();
    @(negedge CLOCK); #1 RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    #1 RESET = 1'b0;
  endtask

  logic [11:0] sq_exp[3]  = '{12'hFFF, 12'h000, 12'hFFF};
  logic [11:0] tri_exp[8] = '{12'h400, 12'h800, 12'hC00, 12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF, 12'h000};
  int f0, o0, k;

  initial begin
    repeat (2) @(negedge CLOCK);
    for (int i = 0; i < 6; i++) begin
      DAC_CLOCK = ~DAC_CLOCK;
      repeat (2) @(negedge CLOCK);
      chk("rst_outs", {DAC_SCLK, DAC_SYNC_N, DAC_DIN, BUSY, OVERRUN, SAMPLE_OUT}, {5'b11000, 12'h000});
    end
    chk("rst_noframe", frames_q.size(), 0);
    #1 RESET = 1'b0;

    ENABLE = 1'b1; WAVE_SEL = 2'b01; FREQ_WORD = 16'h1000; f0 = frames_q.size();
    @(negedge CLOCK); DAC_CLOCK = 1'b1;
    k = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLOCK); #1;
      if (!DAC_SYNC_N) begin k = i; break; end
    end
    chk("saw_sync_edge", k, 3);
    repeat (20) @(negedge CLOCK);
    WAVE_SEL = 2'b11; FREQ_WORD = 16'h4321; DAC_CLOCK = 1'b0;
    wait_idle();
    chk("saw_nframes", frames_q.size() - f0, 1);
    check_frame("saw", f0, 16'h0100);
    chk("saw_sample", SAMPLE_OUT, 12'h100);

    reset_pulse();
    WAVE_SEL = 2'b00; FREQ_WORD = 16'h8000; f0 = frames_q.size();
    for (int i = 0; i < 3; i++) begin
      strobe();
      chk("sq_word", fr(f0 + i).w, {4'b0000, sq_exp[i]});
      chk("sq_sample", SAMPLE_OUT, sq_exp[i]);
    end

    reset_pulse();
    WAVE_SEL = 2'b10; FREQ_WORD = 16'h2000; f0 = frames_q.size();
    for (int i = 0; i < 8; i++) begin
      strobe();
      chk("tri_word", fr(f0 + i).w, {4'b0000, tri_exp[i]});
    end

    reset_pulse();
    WAVE_SEL = 2'b01; FREQ_WORD = 16'h1000; f0 = frames_q.size(); o0 = ovr_cnt;
    @(negedge CLOCK); DAC_CLOCK = 1'b1;
    repeat (10) @(negedge CLOCK); DAC_CLOCK = 1'b0;
    repeat (30) @(negedge CLOCK); DAC_CLOCK = 1'b1;
    repeat (10) @(negedge CLOCK); DAC_CLOCK = 1'b0;
    wait_idle();
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_nframes", frames_q.size() - f0, 1);
    check_frame("ovr_first", f0, 16'h0100);
    strobe();
    check_frame("ovr_next", f0 + 1, 16'h0300);

    reset_pulse();
    f0 = frames_q.size(); o0 = ovr_cnt;
    @(negedge CLOCK); DAC_CLOCK = 1'b1;
    repeat (10) @(negedge CLOCK); DAC_CLOCK = 1'b0;
    repeat (128) @(negedge CLOCK); DAC_CLOCK = 1'b1;
    repeat (10) @(negedge CLOCK); DAC_CLOCK = 1'b0;
    wait_idle();
    chk("gapend_ovr", ovr_cnt - o0, 1);
    chk("gapend_nframes", frames_q.size() - f0, 1);

    reset_pulse();
    ENABLE = 1'b0; f0 = frames_q.size(); o0 = ovr_cnt;
    repeat (3) strobe();
    chk("dis_nframes", frames_q.size() - f0, 0);
    chk("dis_ovr", ovr_cnt - o0, 0);
    @(negedge CLOCK); ENABLE = 1'b1; DAC_CLOCK = 1'b1;
    repeat (20) @(negedge CLOCK); ENABLE = 1'b0; DAC_CLOCK = 1'b0;
    wait_idle();
    check_frame("dis_mid", f0, 16'h0100);

    reset_pulse();
    ENABLE = 1'b1; f0 = frames_q.size();
    @(negedge CLOCK); DAC_CLOCK = 1'b1;
    for (int i = 0; i < 20 && DAC_SYNC_N; i++) @(negedge CLOCK);
    repeat (50) @(negedge CLOCK);
    #1 RESET = 1'b1;
    #1 chk("abort_pins", {DAC_SYNC_N, DAC_SCLK, BUSY}, 3'b110);
    DAC_CLOCK = 1'b0;
    repeat (3) @(negedge CLOCK);
    #1 RESET = 1'b0;
    chk("abort_noframe", frames_q.size() - f0, 0);
    strobe();
    check_frame("abort_after", f0, 16'h0100);

    repeat (5) @(negedge CLOCK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
- Consumes the divided sample strobe DAC_CLOCK (≈100 kHz square wave, CLOCK/1002) and produces one waveform sample per strobe rising edge.
- Waveform comes from a phase accumulator plus a shape select: square, sawtooth, triangle or DC.
- Each sample is serialized as a 16-bit SPI frame to an external 12-bit serial DAC (DAC121S101-class; SYNC_N/SCLK/DIN).
- Sits directly downstream of the DAC clock divider and drives the board DAC pins.

Parameters:
- DATA_W, 12: DAC sample width.
- PHASE_W, 16: phase accumulator width.
- SCLK_DIV, 4: CLOCK cycles per SCLK half-period. SCLK = CLOCK/(2*SCLK_DIV). Legal range ≥1.
- GAP_CYC, 8: minimum CLOCK cycles SYNC_N stays high after a frame.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- DAC_CLOCK  in  1  sample strobe from divider. Treated as a level; its rising edge is detected in the CLOCK domain.
- ENABLE  in  1  1 = advance phase and emit frames.
- WAVE_SEL  in  2  00 square, 01 sawtooth, 10 triangle, 11 DC midscale.
- FREQ_WORD  in  PHASE_W  phase increment per sample.
- DAC_SCLK  out  1  serial clock. Idles high.
- DAC_SYNC_N  out  1  frame sync, active low.
- DAC_DIN  out  1  serial data, MSB first.
- SAMPLE_OUT  out  DATA_W  last sample sent (debug/LED).
- BUSY  out  1  high while a frame or gap is in progress.
- OVERRUN  out  1  one-cycle pulse when a strobe arrives while BUSY.

Behaviour:
- Reset state (async, RESET=1): DAC_SCLK=1, DAC_SYNC_N=1, DAC_DIN=0, SAMPLE_OUT=0, BUSY=0, OVERRUN=0, phase=0, sync/edge flops=0, FSM=IDLE.
- Reset mid-frame aborts the frame immediately; SYNC_N returns high the same instant.
- Strobe detect: DAC_CLOCK passes through two sync flops s1,s2 and a history flop s3. tick = s2 & ~s3.
- On a tick with ENABLE=1, at the same edge: phase <= phase + FREQ_WORD, modulo 2^PHASE_W (wraps silently).
- Shape, computed from the updated phase p (DATA_W=12, PHASE_W=16):
  - square: p[15] ? 0xFFF : 0x000.
  - saw: p[15:4].
  - triangle: p[15] ? ~p[14:3] : p[14:3].
  - DC: 0x800.
- FSM states:
  - IDLE: tick & ENABLE & !BUSY -> LOAD.
  - LOAD (1 cycle): shift_reg <= {4'b0000, sample}; SAMPLE_OUT <= sample; SYNC_N <= 0; DIN <= bit15; SCLK stays 1 -> SHIFT.
  - SHIFT: each bit lasts 2*SCLK_DIV cycles. SCLK is high for the first SCLK_DIV cycles and low for the second. The DAC samples on the falling edge.
  - SHIFT, at bit end: SCLK returns high and DIN presents the next bit. After bit 0 completes, SYNC_N <= 1, DIN <= 0 -> GAP.
  - GAP: count GAP_CYC cycles -> IDLE.
- BUSY = (state != IDLE).
- Latency: counting the CLOCK edge that first samples DAC_CLOCK=1 as edge 0, phase updates at edge 2 and SYNC_N falls at edge 3.
- Frame length: 1 + 16*2*SCLK_DIV cycles (129 by default) with SYNC_N low, then GAP_CYC (8) high.
- Tick while BUSY:
  - The phase still advances, so output frequency stays exact.
  - The sample is dropped and OVERRUN pulses for 1 cycle.
  - The current frame is not disturbed.
- ENABLE=0:
  - Ticks are ignored: no phase change, no frame, no OVERRUN.
  - A frame already in progress completes normally.
- WAVE_SEL and FREQ_WORD are sampled only at the tick edge. Changes mid-frame do not affect the frame in flight.
- Simultaneous tick and GAP->IDLE transition: BUSY is still 1 that cycle, so the tick counts as an overrun.

Decomposition:
- Shared package dac_pkg holds:
  - WAVE_SQUARE, WAVE_SAW, WAVE_TRI and WAVE_DC encodings.
  - FRAME_BITS=16 and CTRL_BITS=4'b0000 (normal power mode).
  - The FSM state encoding: IDLE, LOAD, SHIFT, GAP.
- One natural sub-module, dac_wave_gen: combinational phase+WAVE_SEL -> sample. It is reusable by the future display/preview path.

Test Plan:
- Reset: hold RESET with DAC_CLOCK toggling -> SCLK=1, SYNC_N=1, DIN=0, SAMPLE_OUT=0, BUSY=0, and no frames.
- Saw frame: WAVE_SEL=01, FREQ_WORD=0x1000, one DAC_CLOCK rise.
  - SYNC_N falls at edge 3 and stays low 129 cycles.
  - 16 SCLK falling edges occur, 8 cycles apart.
  - DIN bits captured at the falls = 0x0100; SAMPLE_OUT=0x100.
- Wrap and square: FREQ_WORD=0x8000, square, 3 strobes -> samples 0xFFF, 0x000, 0xFFF (phase 0x8000, 0x0000, 0x8000).
- Triangle: FREQ_WORD=0x2000, 8 strobes -> samples 0x400, 0x800, 0xC00, 0xFFF, 0xBFF, 0x7FF, 0x3FF, 0x000.
- Overrun: second DAC_CLOCK rise 40 cycles after the first.
  - OVERRUN pulses once and only one frame is emitted.
  - The next frame's sample reflects phase advanced twice.
- ENABLE=0 / mid-frame reset:
  - ENABLE=0 with strobes -> no SYNC_N activity and phase unchanged.
  - RESET asserted 50 cycles into a frame -> SYNC_N=1, SCLK=1 immediately; after release the next strobe starts a full frame.
